// File: rtl/crack_pkg.sv
// Shared types and defaults for the candidate-passcode sequencer.
package crack_pkg;

   localparam int W_DEF       = 16;
   localparam int RES_TMO_DEF = 255;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      VERDICT,
      DRAIN,
      FOUND,
      EXHAUST,
      ABORT
   } crack_state_t;

endpackage

// File: rtl/crack_tmo_cnt.sv
// Loadable down-counter; term flags that the loaded budget is used up.
module crack_tmo_cnt #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          term
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign term = (cnt == '0);

endmodule

// File: rtl/crack_ctrl.sv
// Steps candidate passcodes through the sender and stops on accept,
// exhaustion of the search space, or a missing guard verdict.
module crack_ctrl
   import crack_pkg::*;
#(
   parameter int           W          = W_DEF,
   parameter logic [W-1:0] START_CODE = '0,
   parameter logic [W-1:0] LAST_CODE  = '1,
   parameter int           RES_TMO    = RES_TMO_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         rd,
   input  logic         snd_done,
   input  logic         res_v,
   input  logic         res_ok,
   output logic [W-1:0] passcode,
   output logic         En,
   output logic         busy,
   output logic         found,
   output logic [W-1:0] found_code,
   output logic         exhausted,
   output logic         abort,
   output logic [W:0]   tries
);

   localparam int            CW       = $clog2(RES_TMO + 1);
   localparam logic [CW-1:0] TMO_LOAD = CW'(RES_TMO - 1);

   if (START_CODE > LAST_CODE) begin : g_cfg_chk
      $error("crack_ctrl: START_CODE must not exceed LAST_CODE");
   end

   crack_state_t state;
   logic         tmo_load;
   logic         tmo_dec;
   logic         tmo_term;

   // Counter is armed on VERDICT entry and expires after RES_TMO idle cycles
   assign tmo_load = (state == SEND) && snd_done;
   assign tmo_dec  = (state == VERDICT) && !res_v;

   crack_tmo_cnt #(
      .CW(CW)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .load    (tmo_load),
      .load_val(TMO_LOAD),
      .dec     (tmo_dec),
      .term    (tmo_term)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         passcode   <= '0;
         En         <= 1'b0;
         busy       <= 1'b0;
         found      <= 1'b0;
         found_code <= '0;
         exhausted  <= 1'b0;
         abort      <= 1'b0;
         tries      <= '0;
      end else begin
         unique case (state)
            IDLE, FOUND, EXHAUST, ABORT: begin
               if (start) begin
                  passcode   <= START_CODE;
                  tries      <= '0;
                  found      <= 1'b0;
                  found_code <= '0;
                  exhausted  <= 1'b0;
                  abort      <= 1'b0;
                  busy       <= 1'b1;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               if (rd && !snd_done) begin
                  En    <= 1'b1;
                  state <= SEND;
               end
            end
            SEND: begin
               if (snd_done) begin
                  En    <= 1'b0;
                  state <= VERDICT;
               end
            end
            VERDICT: begin
               if (res_v) begin
                  if (res_ok) begin
                     found      <= 1'b1;
                     found_code <= passcode;
                     busy       <= 1'b0;
                     state      <= FOUND;
                  end else begin
                     tries <= tries + 1'b1;
                     // Checked before incrementing so the space never wraps
                     if (passcode == LAST_CODE) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state     <= EXHAUST;
                     end else begin
                        passcode <= passcode + 1'b1;
                        state    <= DRAIN;
                     end
                  end
               end else if (tmo_term) begin
                  abort <= 1'b1;
                  busy  <= 1'b0;
                  state <= ABORT;
               end
            end
            DRAIN: begin
               if (!snd_done) begin
                  state <= LOAD;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crack_ctrl.sv
// Drives crack_ctrl with a sender/guard model and checks each run outcome.
module tb_crack_ctrl;

   localparam int W     = 4;
   localparam int START = 0;
   localparam int LAST  = 15;
   localparam int TMO   = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         rd;
   logic         snd_done;
   logic         res_v;
   logic         res_ok;
   logic [W-1:0] passcode;
   logic         En;
   logic         busy;
   logic         found;
   logic [W-1:0] found_code;
   logic         exhausted;
   logic         abort;
   logic [W:0]   tries;

   int n_chk = 0;
   int n_fail = 0;
   int sent_q[$];
   int accept = -1;
   bit mute = 1'b0;
   bit inj = 1'b0;
   int unstable = 0;

   crack_ctrl #(
      .W         (W),
      .START_CODE(W'(START)),
      .LAST_CODE (W'(LAST)),
      .RES_TMO   (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rd        (rd),
      .snd_done  (snd_done),
      .res_v     (res_v),
      .res_ok    (res_ok),
      .passcode  (passcode),
      .En        (En),
      .busy      (busy),
      .found     (found),
      .found_code(found_code),
      .exhausted (exhausted),
      .abort     (abort),
      .tries     (tries)
   );

   always #5 clk = ~clk;

   // Sender and guard behaviour, acting on falling edges
   initial begin : env
      int s_st = 0;
      int s_cnt = 0;
      int h_cnt = 0;
      int g_cnt = 0;
      int cur = 0;
      snd_done = 1'b0;
      res_v = 1'b0;
      res_ok = 1'b0;
      forever begin
         @(negedge clk);
         res_v = 1'b0;
         if (rst) begin
            s_st = 0;
            g_cnt = 0;
            snd_done = 1'b0;
         end else begin
            if (inj) begin
               res_v = 1'b1;
               res_ok = 1'b1;
               inj = 1'b0;
            end
            case (s_st)
               0: if (En) begin
                  cur = int'(passcode);
                  sent_q.push_back(cur);
                  s_cnt = int'($urandom_range(1, 4));
                  s_st = 1;
               end
               1: begin
                  if (int'(passcode) != cur || !En) unstable++;
                  if (rd) s_cnt--;
                  if (s_cnt == 0) begin
                     snd_done = 1'b1;
                     s_st = 2;
                  end
               end
               2: begin
                  if (!En) begin
                     g_cnt = int'($urandom_range(1, 5));
                     h_cnt = int'($urandom_range(0, 3));
                     s_st = 3;
                  end else if (int'(passcode) != cur) begin
                     unstable++;
                  end
               end
               default: begin
                  if (h_cnt == 0) begin
                     snd_done = 1'b0;
                     s_st = 0;
                  end else begin
                     h_cnt--;
                  end
               end
            endcase
            if (g_cnt > 0) begin
               g_cnt--;
               if (g_cnt == 0 && !mute) begin
                  res_v = 1'b1;
                  res_ok = (cur == accept);
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_en(input logic lvl, input string tag);
      int n = 0;
      while (En !== lvl && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(En), 32'(lvl));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic begin_run(input int acc, input bit m);
      accept = acc;
      mute = m;
      sent_q.delete();
      unstable = 0;
      pulse_start();
   endtask

   // Expected outcome derived from the search rules alone
   task automatic check_run(input int acc, input bit m);
      int exp_q[$];
      int exp_tries;
      int bad;
      bit ef;
      bit ee;
      bit ea;
      ef = 1'b0;
      ee = 1'b0;
      ea = 1'b0;
      bad = 0;
      if (m) begin
         exp_q.push_back(START);
         exp_tries = 0;
         ea = 1'b1;
      end else if (acc >= START && acc <= LAST) begin
         for (int c = START; c <= acc; c++) exp_q.push_back(c);
         exp_tries = acc - START;
         ef = 1'b1;
      end else begin
         for (int c = START; c <= LAST; c++) exp_q.push_back(c);
         exp_tries = LAST - START + 1;
         ee = 1'b1;
      end
      chk("n_sent", sent_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
         if (sent_q[i] != exp_q[i]) bad++;
      chk("sent_seq", bad, 0);
      chk("found", 32'(found), 32'(ef));
      chk("exhausted", 32'(exhausted), 32'(ee));
      chk("abort", 32'(abort), 32'(ea));
      chk("tries", 32'(tries), exp_tries);
      chk("en_idle", 32'(En), 32'd0);
      chk("stable", unstable, 0);
      if (ef) chk("found_code", 32'(found_code), acc);
      if (ee) chk("no_wrap", 32'(passcode), LAST);
   endtask

   initial begin : main
      int n;
      rst = 1'b1;
      start = 1'b0;
      rd = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_passcode", 32'(passcode), 32'd0);
      chk("rst_en", 32'(En), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_found", 32'(found), 32'd0);
      chk("rst_fcode", 32'(found_code), 32'd0);
      chk("rst_exh", 32'(exhausted), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_tries", 32'(tries), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      begin_run(3, 1'b0);
      wait_idle("run_accept3");
      check_run(3, 1'b0);

      begin_run(99, 1'b0);
      wait_idle("run_exhaust");
      check_run(99, 1'b0);

      // Asynchronous reset in the middle of the third send
      begin_run(99, 1'b0);
      wait_en(1'b1, "en_rise_a");
      wait_en(1'b0, "en_fall_a");
      wait_en(1'b1, "en_rise_b");
      wait_en(1'b0, "en_fall_b");
      wait_en(1'b1, "en_rise_c");
      #1 rst = 1'b1;
      #1;
      chk("arst_en", 32'(En), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_tries", 32'(tries), 32'd0);
      chk("arst_passcode", 32'(passcode), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_en", 32'(En), 32'd0);

      // Guard stays silent: abort after exactly TMO cycles in VERDICT
      begin_run(0, 1'b1);
      wait_en(1'b1, "tmo_en_rise");
      wait_en(1'b0, "tmo_en_fall");
      n = 0;
      while (abort !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("abort_latency", n, TMO);
      wait_idle("run_abort");
      check_run(0, 1'b1);
      mute = 1'b0;

      // Stray verdict during SEND and start during VERDICT are ignored
      begin_run(2, 1'b0);
      wait_en(1'b1, "ign_en_rise");
      inj = 1'b1;
      wait_en(1'b0, "ign_en_fall");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("run_ignore");
      check_run(2, 1'b0);

      // Guard ready drops for five cycles mid-send
      begin_run(1, 1'b0);
      wait_en(1'b1, "rd_en_rise");
      rd = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("en_hold_rd_low", 32'(En), 32'd1);
      end
      rd = 1'b1;
      wait_idle("run_rd_drop");
      check_run(1, 1'b0);

      for (int r = 0; r < 6; r++) begin
         int a;
         a = int'($urandom_range(0, 19));
         begin_run(a, 1'b0);
         wait_idle("run_rand");
         check_run(a, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
